// File: rtl/ypbpr_if.sv
// Video bus between the MiST pipeline output and the VGA pin driver:
// RGB/sync/mode inputs in, component or pass-through colour plus syncs out.
interface ypbpr_if;
  logic       ypbpr_en;
  logic [4:0] in_r;
  logic [4:0] in_g;
  logic [4:0] in_b;
  logic       in_hs;
  logic       in_vs;
  logic [4:0] out_r;
  logic [4:0] out_g;
  logic [4:0] out_b;
  logic       out_hs;
  logic       out_vs;

  modport master (
    output ypbpr_en, in_r, in_g, in_b, in_hs, in_vs,
    input  out_r, out_g, out_b, out_hs, out_vs
  );

  modport slave (
    input  ypbpr_en, in_r, in_g, in_b, in_hs, in_vs,
    output out_r, out_g, out_b, out_hs, out_vs
  );
endinterface

// File: rtl/ypbpr_encoder.sv
// Three-stage BT.601 RGB -> YPbPr encoder with matched sync delay and blank levels.
// Optional sync-on-Y (composite sync on the luma channel) via macro YPBPR_SYNC_ON_Y_EN.
module ypbpr_encoder (
  input  logic   clk_sys,
  input  logic   reset_n,
  ypbpr_if.slave vid
);

  // Rows: 0 = Y, 1 = Pb, 2 = Pr.  Columns: 0 = R, 1 = G, 2 = B.
  localparam logic signed [17:0] COEF [3][3] = '{
    '{ 18'sd66,   18'sd129,  18'sd25  },
    '{-18'sd38,  -18'sd74,   18'sd112 },
    '{ 18'sd112, -18'sd94,  -18'sd18  }
  };
  localparam logic signed [17:0] OFFSET [3] = '{18'sd16, 18'sd128, 18'sd128};
  localparam logic signed [17:0] ROUND      = 18'sd128;
  localparam logic signed [17:0] LEVEL_MAX  = 18'sd255;

  localparam logic [4:0] BLANK_Y    = 5'd2;
  localparam logic [4:0] BLANK_PBPR = 5'd16;

  logic [4:0]         rgb_in     [3];
  logic [7:0]         rgb8_reg   [3];
  logic               hs_s1_reg;
  logic               vs_s1_reg;
  logic               en_s1_reg;

  logic signed [17:0] prod_next  [3][3];
  logic signed [17:0] prod_reg   [3][3];
  logic [4:0]         rgb5_reg   [3];
  logic               hs_s2_reg;
  logic               vs_s2_reg;
  logic               en_s2_reg;

  logic signed [17:0] sum_next   [3];
  logic signed [17:0] level_next [3];
  logic [7:0]         clamp_next [3];

  logic [4:0] out_r_next, out_g_next, out_b_next;
  logic       out_hs_next, out_vs_next;
  logic [4:0] out_r_reg, out_g_reg, out_b_reg;
  logic       out_hs_reg, out_vs_reg;

  assign rgb_in[0] = vid.in_r;
  assign rgb_in[1] = vid.in_g;
  assign rgb_in[2] = vid.in_b;

  // Stage 1: 5->8 bit expansion by bit replication, syncs and mode.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) rgb8_reg[i] <= '0;
      hs_s1_reg <= 1'b1;
      vs_s1_reg <= 1'b1;
      en_s1_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) rgb8_reg[i] <= {rgb_in[i], rgb_in[i][4:2]};
      hs_s1_reg <= vid.in_hs;
      vs_s1_reg <= vid.in_vs;
      en_s1_reg <= vid.ypbpr_en;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      for (genvar gj = 0; gj < 3; gj++) begin : g_col
        assign prod_next[gi][gj] = COEF[gi][gj] * $signed({10'd0, rgb8_reg[gj]});
      end
    end
  endgenerate

  // Stage 2: nine products; the original 5-bit colour rides alongside for pass-through.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) prod_reg[i][j] <= '0;
        rgb5_reg[i] <= '0;
      end
      hs_s2_reg <= 1'b1;
      vs_s2_reg <= 1'b1;
      en_s2_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) prod_reg[i][j] <= prod_next[i][j];
        rgb5_reg[i] <= rgb8_reg[i][7:3];
      end
      hs_s2_reg <= hs_s1_reg;
      vs_s2_reg <= vs_s1_reg;
      en_s2_reg <= en_s1_reg;
    end
  end

  // Rounded sum, floor shift, offset and clamp to the 8-bit range.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sum
      assign sum_next[gi]   = prod_reg[gi][0] + prod_reg[gi][1] + prod_reg[gi][2] + ROUND;
      assign level_next[gi] = (sum_next[gi] >>> 8) + OFFSET[gi];
      assign clamp_next[gi] = level_next[gi][17]         ? 8'd0   :
                              (level_next[gi] > LEVEL_MAX) ? 8'd255 :
                              level_next[gi][7:0];
    end
  endgenerate

  always_comb begin
    out_r_next  = rgb5_reg[0];
    out_g_next  = rgb5_reg[1];
    out_b_next  = rgb5_reg[2];
    out_hs_next = hs_s2_reg;
    out_vs_next = vs_s2_reg;
    if (en_s2_reg) begin
      if (!hs_s2_reg || !vs_s2_reg) begin
        out_g_next = BLANK_Y;
        out_b_next = BLANK_PBPR;
        out_r_next = BLANK_PBPR;
      end else begin
        out_g_next = clamp_next[0][7:3];
        out_b_next = clamp_next[1][7:3];
        out_r_next = clamp_next[2][7:3];
      end
`ifdef YPBPR_SYNC_ON_Y_EN
      // Composite sync is low exactly when one of the syncs is active.
      out_hs_next = ~(hs_s2_reg ^ vs_s2_reg);
      out_vs_next = 1'b1;
      if (!out_hs_next) out_g_next = 5'd0;
`endif
    end
  end

  // Stage 3: output registers feeding the DAC.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      out_r_reg  <= '0;
      out_g_reg  <= '0;
      out_b_reg  <= '0;
      out_hs_reg <= 1'b1;
      out_vs_reg <= 1'b1;
    end else begin
      out_r_reg  <= out_r_next;
      out_g_reg  <= out_g_next;
      out_b_reg  <= out_b_next;
      out_hs_reg <= out_hs_next;
      out_vs_reg <= out_vs_next;
    end
  end

  assign vid.out_r  = out_r_reg;
  assign vid.out_g  = out_g_reg;
  assign vid.out_b  = out_b_reg;
  assign vid.out_hs = out_hs_reg;
  assign vid.out_vs = out_vs_reg;

endmodule

// File: tb/tb_ypbpr_encoder.sv
// Randomised bench for ypbpr_encoder against an arithmetic reference model
// with a 3-sample delay line; also checks the directed colour/blank values.
module tb_ypbpr_encoder;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  ypbpr_if vid ();

  ypbpr_encoder dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .vid     (vid)
  );

  always #5 clk_sys = ~clk_sys;

  // {r, g, b, hs, vs}
  localparam logic [16:0] RST_OUT = {5'd0, 5'd0, 5'd0, 1'b1, 1'b1};
  logic [16:0] pipe [3];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div256(input int v);
    if (v >= 0) return v / 256;
    return -((-v + 255) / 256);
  endfunction

  function automatic int clamp8(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic logic [16:0] ref_out(input logic en, input int r5, input int g5,
                                          input int b5, input logic hs, input logic vs);
    int r, g, b, y, pb, pr, oy, opb, opr;
    logic ohs, ovs;
    if (!en) return {5'(r5), 5'(g5), 5'(b5), hs, vs};
    r  = r5 * 8 + r5 / 4;
    g  = g5 * 8 + g5 / 4;
    b  = b5 * 8 + b5 / 4;
    y  = clamp8(16  + floor_div256( 66 * r + 129 * g +  25 * b + 128));
    pb = clamp8(128 + floor_div256(-38 * r -  74 * g + 112 * b + 128));
    pr = clamp8(128 + floor_div256(112 * r -  94 * g -  18 * b + 128));
    oy = y / 8; opb = pb / 8; opr = pr / 8;
    if (!hs || !vs) begin
      oy = 2; opb = 16; opr = 16;
    end
    ohs = hs;
    ovs = vs;
`ifdef YPBPR_SYNC_ON_Y_EN
    ohs = (hs == vs);
    ovs = 1'b1;
    if (!ohs) oy = 0;
`endif
    return {5'(opr), 5'(oy), 5'(opb), ohs, ovs};
  endfunction

  task automatic drive(input logic en, input int r, input int g, input int b,
                       input logic hs, input logic vs);
    vid.ypbpr_en = en;
    vid.in_r     = 5'(r);
    vid.in_g     = 5'(g);
    vid.in_b     = 5'(b);
    vid.in_hs    = hs;
    vid.in_vs    = vs;
  endtask

  task automatic drive_random();
    drive(1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) != 0));
  endtask

  task automatic check_outputs(input string tag, input logic [16:0] exp);
    check({tag, ".r"},  int'(vid.out_r),  int'(exp[16:12]));
    check({tag, ".g"},  int'(vid.out_g),  int'(exp[11:7]));
    check({tag, ".b"},  int'(vid.out_b),  int'(exp[6:2]));
    check({tag, ".hs"}, int'(vid.out_hs), int'(exp[1]));
    check({tag, ".vs"}, int'(vid.out_vs), int'(exp[0]));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step(input string tag);
    @(posedge clk_sys);
    if (reset_n) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = ref_out(vid.ypbpr_en, int'(vid.in_r), int'(vid.in_g), int'(vid.in_b),
                        vid.in_hs, vid.in_vs);
    end
    #1;
    check_outputs(tag, pipe[2]);
    $display("[%0t] %s en=%0b in=(%0d,%0d,%0d,%0b,%0b) out=(%0d,%0d,%0d,%0b,%0b)",
             $time, tag, vid.ypbpr_en, vid.in_r, vid.in_g, vid.in_b, vid.in_hs, vid.in_vs,
             vid.out_r, vid.out_g, vid.out_b, vid.out_hs, vid.out_vs);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) pipe[i] = RST_OUT;
  endtask

  // Apply one sample then flush with quiet inputs so it reaches the output.
  task automatic directed(input string tag, input logic en, input int r, input int g,
                          input int b, input logic hs, input logic vs);
    drive(en, r, g, b, hs, vs);
    step({tag, "_in"});
    drive(en, 0, 0, 0, 1'b1, 1'b1);
    step({tag, "_d1"});
    step({tag, "_d2"});
  endtask

  initial begin
    reset_model();
    drive(1'b1, 7, 7, 7, 1'b0, 1'b0);

    // Reset held with random inputs: outputs stay at reset values.
    for (int i = 0; i < 4; i++) begin
      drive_random();
      step("reset_hold");
    end

    // Release away from the edge; first valid sample appears on the 3rd edge.
    drive(1'b1, 31, 31, 31, 1'b1, 1'b1);
    reset_n = 1'b1;
    step("post_rst1");
    check("post_rst1_g", int'(vid.out_g), 0);
    step("post_rst2");
    check("post_rst2_g", int'(vid.out_g), 0);
    step("post_rst3");
    check("post_rst3_white_g", int'(vid.out_g), 29);

    directed("white", 1'b1, 31, 31, 31, 1'b1, 1'b1);
    check("white_y",  int'(vid.out_g), 29);
    check("white_pb", int'(vid.out_b), 16);
    check("white_pr", int'(vid.out_r), 16);

    directed("red", 1'b1, 31, 0, 0, 1'b1, 1'b1);
    check("red_y",  int'(vid.out_g), 10);
    check("red_pb", int'(vid.out_b), 11);
    check("red_pr", int'(vid.out_r), 30);

    directed("blank", 1'b1, 0, 0, 0, 1'b0, 1'b1);
`ifdef YPBPR_SYNC_ON_Y_EN
    check("blank_y",  int'(vid.out_g),  0);
    check("blank_hs", int'(vid.out_hs), 0);
`else
    check("blank_y",  int'(vid.out_g),  2);
    check("blank_hs", int'(vid.out_hs), 0);
`endif
    check("blank_pb", int'(vid.out_b),  16);
    check("blank_pr", int'(vid.out_r),  16);
    check("blank_vs", int'(vid.out_vs), 1);

    directed("pass", 1'b0, 5, 10, 20, 1'b0, 1'b1);
    check("pass_r",  int'(vid.out_r),  5);
    check("pass_g",  int'(vid.out_g),  10);
    check("pass_b",  int'(vid.out_b),  20);
    check("pass_hs", int'(vid.out_hs), 0);

    // Mode toggling on every sample with a fixed colour.
    for (int i = 0; i < 12; i++) begin
      drive(1'(i % 2), 31, 0, 0, 1'b1, 1'b1);
      step("toggle");
    end

    // Random traffic with mid-line asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      if (i == 150 || i == 300) begin
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        reset_model();
        check_outputs("async_rst", RST_OUT);
        @(posedge clk_sys);
        #2;
        reset_n = 1'b1;
      end
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
